// File: rtl/seq_det_pkg.sv
// Shared constants and types for the programmable sequence detector.
//   SEQ_MAX_LEN      default longest pattern, in bits
//   SEQ_LEN_W        width of length/fill fields for SEQ_MAX_LEN
//   mode_e           output mode: Mealy (combinational) or Moore (registered)
//   SEQ_DEF_PATTERN  pattern loaded at reset (LSB = last bit received)
//   SEQ_DEF_LEN      pattern length loaded at reset
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN = 8;
  localparam int unsigned SEQ_LEN_W   = $clog2(SEQ_MAX_LEN) + 1;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

  localparam logic [SEQ_MAX_LEN-1:0] SEQ_DEF_PATTERN = 8'b0000_0101;
  localparam int unsigned            SEQ_DEF_LEN     = 3;

endpackage

// File: rtl/seq_det_cmp.sv
// Length-variable, masked compare of {history, x} against the pattern.
//   valid_i  qualified sample strobe (already excludes config loads)
//   x_i      current serial bit, compared against pat_i[0]
//   hist_i   shift history, hist_i[0] = most recent accepted bit
//   pat_i    pattern, pat_i[len-1] first bit, pat_i[0] last bit
//   len_i    active pattern length (already clamped), 0 = disabled
//   fill_i   number of valid history bits
//   match_o  combinational match indication for this sample
module seq_det_cmp #(
  parameter int unsigned MAX_LEN = seq_det_pkg::SEQ_MAX_LEN
) (
  input  logic                       valid_i,
  input  logic                       x_i,
  input  logic [MAX_LEN-1:0]         hist_i,
  input  logic [MAX_LEN-1:0]         pat_i,
  input  logic [$clog2(MAX_LEN):0]   len_i,
  input  logic [$clog2(MAX_LEN):0]   fill_i,
  output logic                       match_o
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

  logic [MAX_LEN-1:0] seq;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic [LEN_W:0]     len_ext;
  logic               fill_ok;

  always_comb begin
    seq  = {hist_i[MAX_LEN-2:0], x_i};
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_i) begin
        mask[i] = 1'b1;
      end
    end
    // fill >= len-1 evaluated as fill+1 >= len to avoid underflow at len=0
    fill_p1 = {1'b0, fill_i} + {{LEN_W{1'b0}}, 1'b1};
    len_ext = {1'b0, len_i};
    fill_ok = (fill_p1 >= len_ext);
    match_o = valid_i & (len_i != '0) & fill_ok & (((seq ^ pat_i) & mask) == '0);
  end

endmodule

// File: rtl/seq_det_prog_mealy_moore.sv
// Programmable serial bit-sequence detector with Mealy/Moore output and a
// saturating match counter.
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   x          serial data bit, sampled only when in_valid=1
//   in_valid   sample qualifier
//   cfg_load   1-cycle strobe capturing cfg_pat/cfg_len/cfg_ovl/cfg_moore;
//              clears history and fill, drops a same-cycle sample
//   cfg_pat    pattern, cfg_pat[len-1] first bit, cfg_pat[0] last bit
//   cfg_len    pattern length, 0 disables, >MAX_LEN clamps to MAX_LEN
//   cfg_ovl    1 = overlapping matches allowed
//   cfg_moore  0 = Mealy output, 1 = Moore output
//   clr_cnt    synchronous clear of match_cnt (wins over increment)
//   y          match indication
//   match_cnt  saturating match count
//   fill       valid history bits, capped at the active length
module seq_det_prog_mealy_moore
  import seq_det_pkg::*;
#(
  parameter int unsigned          MAX_LEN     = SEQ_MAX_LEN,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
  parameter int unsigned          DEF_LEN     = SEQ_DEF_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       in_valid,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pat,
  input  logic [$clog2(MAX_LEN):0]   cfg_len,
  input  logic                       cfg_ovl,
  input  logic                       cfg_moore,
  input  logic                       clr_cnt,
  output logic                       y,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(MAX_LEN):0]   fill
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

  localparam logic [LEN_W-1:0] RST_LEN = clamp_len(LEN_W'(DEF_LEN));

  // Shadow configuration
  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  mode_e              mode_q, mode_d;

  // Detector state
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q,    y_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic sample_v;
  logic match_now;

  // A config load consumes the cycle: any concurrent sample is dropped.
  assign sample_v = in_valid & ~cfg_load;

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .valid_i (sample_v),
    .x_i     (x),
    .hist_i  (hist_q),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .fill_i  (fill_q),
    .match_o (match_now)
  );

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    mode_d = mode_q;
    hist_d = hist_q;
    fill_d = fill_q;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = clamp_len(cfg_len);
      ovl_d  = cfg_ovl;
      mode_d = mode_e'(cfg_moore);
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (!ovl_q && match_now) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = {hist_q[MAX_LEN-2:0], x};
        if (fill_q < len_q) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
    end
  end

  // Moore flop is loaded only while in Moore mode; a pulse already
  // registered finishes its cycle even if the mode changes underneath it.
  assign y_d = match_now & (mode_q == MODE_MOORE);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match_now && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b1;
      mode_q <= MODE_MEALY;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      mode_q <= mode_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y         = (mode_q == MODE_MOORE) ? y_q : match_now;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_det_prog_mealy_moore.sv
module tb_seq_det_prog_mealy_moore;

  localparam int MAXL = 8;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            x = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
  logic [MAXL-1:0] cfg_pat = '0;
  logic [3:0]      cfg_len = '0;
  logic            cfg_ovl = 1'b0, cfg_moore = 1'b0, clr_cnt = 1'b0;
  logic            y;
  logic [CNTW-1:0] match_cnt;
  logic [3:0]      fill;

  seq_det_prog_mealy_moore #(
    .MAX_LEN (MAXL),
    .CNT_W   (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cfg_moore (cfg_moore),
    .clr_cnt   (clr_cnt),
    .y         (y),
    .match_cnt (match_cnt),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the received bit stream since the last clear, plus config.
  logic [MAXL-1:0] m_pat;
  int              m_len;
  bit              m_ovl, m_moore, m_yq;
  int              m_cnt;
  bit              hq[$];

  function automatic void model_reset();
    m_pat   = 8'b101;
    m_len   = 3;
    m_ovl   = 1'b1;
    m_moore = 1'b0;
    m_yq    = 1'b0;
    m_cnt   = 0;
    hq.delete();
  endfunction

  // Pattern matches if the last len-1 stored bits followed by xb spell it.
  function automatic bit model_match(bit xb, bit v);
    bit b;
    if (!v || m_len == 0) return 1'b0;
    if (hq.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? xb : hq[hq.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_fill();
    return (hq.size() < m_len) ? hq.size() : m_len;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input bit xb, input bit v, input bit ld, input bit clr,
                      input logic [MAXL-1:0] p, input int l, input bit o, input bit mo);
    bit mm;
    x = xb; in_valid = v; cfg_load = ld; clr_cnt = clr;
    cfg_pat = p; cfg_len = 4'(l); cfg_ovl = o; cfg_moore = mo;
    @(negedge clk);
    mm = model_match(xb, v && !ld);
    check("y", y, m_moore ? m_yq : mm);
    check("cnt", match_cnt, m_cnt);
    check("fill", fill, model_fill());
    @(posedge clk);
    m_yq = m_moore && mm;
    if (clr) m_cnt = 0;
    else if (mm && m_cnt < CMAX) m_cnt++;
    if (ld) begin
      m_pat = p; m_len = (l > MAXL) ? MAXL : l; m_ovl = o; m_moore = mo;
      hq.delete();
    end else if (v) begin
      if (!m_ovl && mm) hq.delete();
      else begin
        hq.push_back(xb);
        if (hq.size() > MAXL) void'(hq.pop_front());
      end
    end
    #1;
  endtask

  task automatic bit_in(input bit b);
    step(b, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [MAXL-1:0] p, input int l, input bit o, input bit mo, input bit clr);
    step(1'b0, 1'b0, 1'b1, clr, p, l, o, mo);
  endtask

  task automatic bits_msb(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic do_reset();
    x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_y", y, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_fill", fill, 0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Legacy 101 overlapping Mealy
    bits_msb(32'b10101, 5);
    check("t1_cnt", match_cnt, 2);

    // 1101, non-overlap, Moore
    load(8'b1101, 4, 1'b0, 1'b1, 1'b1);
    bits_msb(32'b1101101, 7);
    idle();
    check("t2_cnt", match_cnt, 1);

    // 1101, overlap, Moore
    load(8'b1101, 4, 1'b1, 1'b1, 1'b1);
    bits_msb(32'b1101101, 7);
    idle();
    check("t3_cnt", match_cnt, 2);

    // 101 with valid gaps
    load(8'b101, 3, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      bit_in(i[0] ? 1'b0 : 1'b1);
      if (i != 0) repeat (3) idle();
    end
    check("t4_cnt", match_cnt, 1);

    // Saturation with overlapping "11"
    load(8'b11, 2, 1'b1, 1'b0, 1'b1);
    repeat (CMAX + 20) bit_in(1'b1);
    check("t5_sat", match_cnt, CMAX);
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0);
    check("t5_clr", match_cnt, 0);

    // len=0 disables detection
    load(8'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (20) bit_in(1'b0);
    check("t6_len0", match_cnt, 0);

    // len=15 clamps to MAX_LEN
    load(8'b10110011, 15, 1'b1, 1'b0, 1'b0);
    bits_msb(32'b10110011, 8);
    check("t6_len15_cnt", match_cnt, 1);
    check("t6_len15_fill", fill, MAXL);

    // reset after "10", then "1": no match
    do_reset();
    bits_msb(32'b10, 2);
    do_reset();
    bit_in(1'b1);
    check("t6_rst_cnt", match_cnt, 0);

    // cfg_load with in_valid drops the bit
    load(8'b1, 1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'b1, 1, 1'b1, 1'b0);
    check("t6_ldv_cnt", match_cnt, 0);
    bit_in(1'b1);
    check("t6_ldv_after", match_cnt, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 700; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        load(MAXL'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      end else if (r < 5) begin
        do_reset();
      end else begin
        step(1'($urandom), ($urandom_range(0, 9) < 7), 1'b0, ($urandom_range(0, 39) == 0),
             '0, 0, 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
